gerador_imediato: RTL and testbench
===================================

Name: gerador_imediato

Overview:
- Immediate generator for the ID stage of the RV32I pipeline.
- Decodes the opcode of a 32-bit instruction and produces the sign-extended 32-bit immediate for I, S, B, U and J formats.
- Output `immediate` is purely combinational, so decode in the same cycle sees it.
- A registered copy (one-cycle latency) is also provided for the ID/EX boundary, together with format and valid flags.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DEFAULT_IMM, 32'h0000_0000, value driven for unrecognised opcodes.

Ports:
- clk  in  1  clock; all registered outputs update on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instruction  in  32  instruction word under decode.
- instr_valid  in  1  qualifies `instruction` for the registered path.
- immediate  out  32  combinational immediate.
- imm_type  out  3  combinational format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- imm_known  out  1  combinational; 1 when the opcode is recognised.
- immediate_q  out  32  registered immediate.
- imm_type_q  out  3  registered format code.
- imm_valid_q  out  1  registered; equals instr_valid & imm_known from the previous cycle.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Combinational decode, keyed on opcode = instruction[6:0]:
  - 0000011 (load), 1100111 (JALR), 0010011 (OP-IMM): I-type. Immediate = sign-extend instruction[31:20].
  - Exception within OP-IMM: when funct3 = 001 or 101, type is SHAMT and immediate = zero-extend instruction[24:20]. Bits [31:25] are ignored.
  - 0100011 (store): S-type. Immediate = sign-extend {instruction[31:25], instruction[11:7]}.
  - 1100011 (branch): B-type. Immediate = sign-extend {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}. This is a byte offset and bit 0 is always 0.
  - 0110111 (LUI), 0010111 (AUIPC): U-type. Immediate = {instruction[31:12], 12'b0}.
  - 1101111 (JAL): J-type. Immediate = sign-extend {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}.
  - Any other opcode (including R-type 0110011 and 1111111): immediate = DEFAULT_IMM, imm_type = 0, imm_known = 0.
- Sign extension always uses instruction[31]; there is no dependence on funct7 except as noted for SHAMT.
- Combinational outputs have no latches and no dependence on clk or rst_n; they settle within the same delta as `instruction`.
- Registered path:
  - On each rising clk edge, immediate_q and imm_type_q load their combinational counterparts unconditionally.
  - imm_valid_q <= instr_valid & imm_known.
- Reset: rst_n low clears immediate_q, imm_type_q and imm_valid_q to 0 immediately, independent of clk. Combinational outputs are unaffected by reset.
- Reset deasserted mid-stream: the first edge after deassertion captures the current instruction normally.
- X on opcode bits propagates; no X-masking is required.

Decomposition:
- Shared package `riscv_pkg`:
  - opcode localparams (OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL);
  - imm_type enum (IMM_NONE..IMM_SHAMT);
  - funct3 constants for SLLI/SRLI/SRAI.
- Sub-module `imm_decode_comb` holds the pure combinational opcode-to-immediate/type logic.
- The top level adds the output register stage.

Test Plan:
- lw x2,4(x1) = 32'h0040_A103 -> immediate 4, imm_type I, imm_known 1. With instr_valid=1, after one edge immediate_q 4 and imm_valid_q 1.
- sw with instruction[31:25]=0, instruction[11:7]=00100, opcode 0100011 (32'h0020_A223) -> immediate 4, type S.
- beq with instruction[11:7]=00010, other imm bits 0 (32'h0031_0163) -> immediate 2, type B.
- Opcode 1111111 with all other bits 0 (32'h0000_007F) -> immediate 0, imm_known 0; imm_valid_q 0 after an edge even with instr_valid=1.
- Negative and upper formats:
  - addi x1,x0,-1 (32'hFFF0_0093) -> 32'hFFFF_FFFF;
  - lui 32'h1234_50B7 -> 32'h1234_5000;
  - jal with imm -2 (32'hFFFF_F0EF) -> 32'hFFFF_FFFE;
  - srai shamt 5 (32'h4050_D093) -> 5.
- Reset mid-operation: load registers with nonzero values, assert rst_n low between edges -> immediate_q, imm_type_q, imm_valid_q read 0 immediately, while combinational immediate remains correct.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode, funct3 and immediate-format definitions
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Shift-immediate funct3 codes; SRLI and SRAI share 101 and differ in funct7
    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRLI = 3'b101;
    localparam logic [2:0] F3_SRAI = 3'b101;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6
    } imm_type_e;

endpackage

// File: rtl/imm_decode_comb.sv
// rtl/imm_decode_comb.sv - combinational opcode-to-immediate/format decoder
module imm_decode_comb
    import riscv_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [XLEN-1:0] DEFAULT_IMM = '0
) (
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] immediate,
    output imm_type_e       imm_type,
    output logic            imm_known
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       sign;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign sign   = instruction[31];

    // Select format from opcode and assemble the sign-extended immediate
    always_comb begin
        immediate = DEFAULT_IMM;
        imm_type  = IMM_NONE;
        imm_known = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                immediate = {{20{sign}}, instruction[31:20]};
                imm_type  = IMM_I;
                imm_known = 1'b1;
            end
            OPC_OPIMM: begin
                imm_known = 1'b1;
                if (funct3 == F3_SLLI || funct3 == F3_SRLI) begin
                    // Shift amount only; funct7 in [31:25] is not part of the value
                    immediate = {27'b0, instruction[24:20]};
                    imm_type  = IMM_SHAMT;
                end else begin
                    immediate = {{20{sign}}, instruction[31:20]};
                    imm_type  = IMM_I;
                end
            end
            OPC_STORE: begin
                immediate = {{20{sign}}, instruction[31:25], instruction[11:7]};
                imm_type  = IMM_S;
                imm_known = 1'b1;
            end
            OPC_BRANCH: begin
                immediate = {{19{sign}}, instruction[31], instruction[7],
                             instruction[30:25], instruction[11:8], 1'b0};
                imm_type  = IMM_B;
                imm_known = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                immediate = {instruction[31:12], 12'b0};
                imm_type  = IMM_U;
                imm_known = 1'b1;
            end
            OPC_JAL: begin
                immediate = {{11{sign}}, instruction[31], instruction[19:12],
                             instruction[20], instruction[30:21], 1'b0};
                imm_type  = IMM_J;
                imm_known = 1'b1;
            end
            default: begin
                immediate = DEFAULT_IMM;
                imm_type  = IMM_NONE;
                imm_known = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/gerador_imediato.sv
// rtl/gerador_imediato.sv - RV32I immediate generator with ID/EX output register
module gerador_imediato
    import riscv_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] DEFAULT_IMM = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instruction,
    input  logic            instr_valid,
    output logic [XLEN-1:0] immediate,
    output logic [2:0]      imm_type,
    output logic            imm_known,
    output logic [XLEN-1:0] immediate_q,
    output logic [2:0]      imm_type_q,
    output logic            imm_valid_q
);

    imm_type_e       type_comb;
    logic [XLEN-1:0] immediate_d;
    logic [2:0]      imm_type_d;
    logic            imm_valid_d;
    logic [XLEN-1:0] immediate_r;
    logic [2:0]      imm_type_r;
    logic            imm_valid_r;

    imm_decode_comb #(
        .XLEN        (XLEN),
        .DEFAULT_IMM (DEFAULT_IMM)
    ) u_decode (
        .instruction (instruction),
        .immediate   (immediate),
        .imm_type    (type_comb),
        .imm_known   (imm_known)
    );

    assign imm_type    = type_comb;
    assign immediate_d = immediate;
    assign imm_type_d  = type_comb;
    assign imm_valid_d = instr_valid & imm_known;

    // ID/EX capture: immediate and format load every edge, valid is qualified
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            immediate_r <= '0;
            imm_type_r  <= '0;
            imm_valid_r <= 1'b0;
        end else begin
            immediate_r <= immediate_d;
            imm_type_r  <= imm_type_d;
            imm_valid_r <= imm_valid_d;
        end
    end

    assign immediate_q = immediate_r;
    assign imm_type_q  = imm_type_r;
    assign imm_valid_q = imm_valid_r;

endmodule

// File: tb/tb_gerador_imediato.sv
// tb/tb_gerador_imediato.sv - self-checking bench for gerador_imediato
module tb_gerador_imediato;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] immediate;
    logic [2:0]  imm_type;
    logic        imm_known;
    logic [31:0] immediate_q;
    logic [2:0]  imm_type_q;
    logic        imm_valid_q;

    int checks = 0;
    int errors = 0;

    gerador_imediato dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .immediate   (immediate),
        .imm_type    (imm_type),
        .imm_known   (imm_known),
        .immediate_q (immediate_q),
        .imm_type_q  (imm_type_q),
        .imm_valid_q (imm_valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: immediate built from field values with plain integer arithmetic
    function automatic void model(input logic [31:0] ins, output logic [31:0] imm,
                                  output logic [2:0] ty, output logic kn);
        int s;
        int u;
        int opc;
        int f3;
        s   = int'(ins);
        u   = s;
        opc = u & 127;
        f3  = (u >>> 12) & 7;
        kn  = 1'b1;
        if (opc == 19 && (f3 == 1 || f3 == 5)) begin
            imm = 32'((u >>> 20) & 31);
            ty  = 3'd6;
        end else if (opc == 3 || opc == 19 || opc == 103) begin
            imm = 32'(s >>> 20);
            ty  = 3'd1;
        end else if (opc == 35) begin
            imm = 32'((s >>> 25) * 32 + ((u >>> 7) & 31));
            ty  = 3'd2;
        end else if (opc == 99) begin
            imm = 32'((s >>> 31) * 4096 + ((u >>> 7) & 1) * 2048
                      + ((u >>> 25) & 63) * 32 + ((u >>> 8) & 15) * 2);
            ty  = 3'd3;
        end else if (opc == 55 || opc == 23) begin
            imm = 32'(u - (u & 4095));
            ty  = 3'd4;
        end else if (opc == 111) begin
            imm = 32'((s >>> 31) * 1048576 + ((u >>> 12) & 255) * 4096
                      + ((u >>> 20) & 1) * 2048 + ((u >>> 21) & 1023) * 2);
            ty  = 3'd5;
        end else begin
            imm = 32'h0;
            ty  = 3'd0;
            kn  = 1'b0;
        end
    endfunction

    // Drive one instruction, check the combinational and then the registered view
    task automatic apply(input string tag, input logic [31:0] ins, input logic vld);
        logic [31:0] e_imm;
        logic [2:0]  e_ty;
        logic        e_kn;
        model(ins, e_imm, e_ty, e_kn);
        @(negedge clk);
        instruction = ins;
        instr_valid = vld;
        #1;
        check({tag, ".imm"},   immediate, e_imm);
        check({tag, ".type"},  {29'b0, imm_type}, {29'b0, e_ty});
        check({tag, ".known"}, {31'b0, imm_known}, {31'b0, e_kn});
        @(posedge clk);
        #1;
        check({tag, ".imm_q"},   immediate_q, e_imm);
        check({tag, ".type_q"},  {29'b0, imm_type_q}, {29'b0, e_ty});
        check({tag, ".valid_q"}, {31'b0, imm_valid_q}, {31'b0, vld & e_kn});
    endtask

    // Spot checks against hand-derived constants, independent of the model
    task automatic direct(input string tag, input logic [31:0] ins,
                          input logic [31:0] e_imm, input logic [2:0] e_ty);
        @(negedge clk);
        instruction = ins;
        instr_valid = 1'b1;
        #1;
        check({tag, ".const_imm"},  immediate, e_imm);
        check({tag, ".const_type"}, {29'b0, imm_type}, {29'b0, e_ty});
    endtask

    logic [6:0] opc_list [10];

    initial begin
        logic [31:0] r;
        logic [31:0] e_imm;
        logic [2:0]  e_ty;
        logic        e_kn;

        opc_list = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                     7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1111111};

        rst_n       = 1'b0;
        instruction = 32'h0040_A103;
        instr_valid = 1'b1;
        #1;
        check("reset.imm_q",   immediate_q, 32'h0);
        check("reset.type_q",  {29'b0, imm_type_q}, 32'h0);
        check("reset.valid_q", {31'b0, imm_valid_q}, 32'h0);
        check("reset.comb_imm", immediate, 32'h4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        direct("lw",    32'h0040_A103, 32'h0000_0004, 3'd1);
        direct("sw",    32'h0020_A223, 32'h0000_0004, 3'd2);
        direct("beq",   32'h0031_0163, 32'h0000_0002, 3'd3);
        direct("bad",   32'h0000_007F, 32'h0000_0000, 3'd0);
        direct("addi",  32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1);
        direct("lui",   32'h1234_50B7, 32'h1234_5000, 3'd4);
        direct("jal",   32'hFFFF_F0EF, 32'hFFFF_FFFE, 3'd5);
        direct("srai",  32'h4050_D093, 32'h0000_0005, 3'd6);

        apply("lw",    32'h0040_A103, 1'b1);
        apply("bad",   32'h0000_007F, 1'b1);
        apply("sw",    32'h0020_A223, 1'b0);
        apply("beq",   32'h0031_0163, 1'b1);
        apply("addi",  32'hFFF0_0093, 1'b1);
        apply("lui",   32'h1234_50B7, 1'b1);
        apply("jal",   32'hFFFF_F0EF, 1'b1);
        apply("srai",  32'h4050_D093, 1'b1);
        apply("slli",  32'hFE10_9093, 1'b1);
        apply("rtype", 32'h0020_81B3, 1'b1);

        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            if (i % 10 == 9) r[6:0] = 7'($urandom);
            else             r[6:0] = opc_list[$urandom_range(0, 9)];
            apply("rand", r, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between edges with nonzero registered state
        apply("pre_rst", 32'hFFF0_0093, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst.imm_q",   immediate_q, 32'h0);
        check("async_rst.type_q",  {29'b0, imm_type_q}, 32'h0);
        check("async_rst.valid_q", {31'b0, imm_valid_q}, 32'h0);
        check("async_rst.comb",    immediate, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("rst_hold.imm_q", immediate_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        instruction = 32'hFFFF_F0EF;
        instr_valid = 1'b1;
        model(instruction, e_imm, e_ty, e_kn);
        @(posedge clk);
        #1;
        check("post_rst.imm_q",   immediate_q, e_imm);
        check("post_rst.type_q",  {29'b0, imm_type_q}, {29'b0, e_ty});
        check("post_rst.valid_q", {31'b0, imm_valid_q}, {31'b0, e_kn});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
